// File: rtl/ru_mem_ctrl_pkg.sv
// Shared types for the data-memory controller: access sizes, FSM states and
// the size/alignment decode used by both the controller and the lane aligner.
package ru_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        RMW_RD,
        DONE
    } mem_state_t;

    // The unused 2'b11 encoding behaves as a full word.
    function automatic mem_size_t decode_size(input logic [1:0] raw);
        case (raw)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_HALF: return lo[0];
            SZ_WORD: return (lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ru_mem_ctrl_if.sv
// Bundle between the core load/store stage, the controller and the word RAM.
// The core/RAM side uses the master modport, the controller uses slave.
interface ru_mem_ctrl_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  req_read;
    logic                  req_write;
    logic [31:0]           req_addr;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  busy;
    logic                  ack;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  misaligned;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic                  ram_write_en;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport master (
        output req_read, req_write, req_addr, req_size, req_unsigned, req_wdata, ram_dout,
        input  busy, ack, rdata, misaligned, ram_addr, ram_din, ram_write_en
    );

    modport slave (
        input  req_read, req_write, req_addr, req_size, req_unsigned, req_wdata, ram_dout,
        output busy, ack, rdata, misaligned, ram_addr, ram_din, ram_write_en
    );
endinterface

// File: rtl/ru_mem_ctrl_lane_align.sv
// Combinational lane handling: extracts and extends a load from a RAM word,
// and merges sub-word store data into the RAM word for read-modify-write.
module ru_lane_align
    import ru_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  mem_size_t   size_i,
    input  logic        unsigned_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = word_i[{lane_i, 3'b000} +: 8];
        half_v  = lane_i[1] ? word_i[31:16] : word_i[15:0];
        load_o  = word_i;
        merge_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                load_o = unsigned_i ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
                merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_o = unsigned_i ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
                if (lane_i[1]) merge_o[31:16] = wdata_i;
                else           merge_o[15:0]  = wdata_i;
            end
            default: begin
                load_o  = word_i;
                merge_o = word_i;
            end
        endcase
    end

endmodule

// File: rtl/ru_mem_ctrl.sv
// Data-memory request controller: turns core load/store requests into word
// accesses on a RAM with one-cycle registered read, stalling the core meanwhile.
module ru_mem_ctrl
    import ru_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    ru_mem_ctrl_if.slave  bus_if
);

    mem_state_t            state_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    mem_size_t             size_q;
    logic                  uns_q;
    logic [15:0]           wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic      idle;
    logic      req_any;
    logic      req_mis;
    logic      accept;
    mem_size_t req_size_dec;
    logic [31:0] load_word;
    logic [31:0] merge_word;
    logic      unused_addr_bits;

    assign unused_addr_bits = ^{bus_if.req_addr[31:ADDR_WIDTH+2], bus_if.req_wdata[31:16]};

    assign idle         = (state_q == IDLE);
    assign req_any      = bus_if.req_read | bus_if.req_write;
    assign req_size_dec = decode_size(bus_if.req_size);
    assign req_mis      = is_misaligned(req_size_dec, bus_if.req_addr[1:0]);
    assign accept       = idle & req_any & ~req_mis;

    ru_lane_align u_lane_align (
        .word_i     (bus_if.ram_dout),
        .lane_i     (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .load_o     (load_word),
        .merge_o    (merge_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= SZ_WORD;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= bus_if.req_addr[ADDR_WIDTH+1:0];
                        size_q  <= req_size_dec;
                        uns_q   <= bus_if.req_unsigned;
                        wdata_q <= bus_if.req_wdata[15:0];
                        // A simultaneous read and write is treated as a read only.
                        if (bus_if.req_read)            state_q <= RD;
                        else if (req_size_dec == SZ_WORD) state_q <= DONE;
                        else                            state_q <= RMW_RD;
                    end
                end
                RD: begin
                    rdata_q <= load_word;
                    state_q <= DONE;
                end
                RMW_RD:  state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reset gates every strobe so an aborted RMW never reaches the RAM.
    assign bus_if.busy         = ~rst & (accept | (state_q == RD) | (state_q == RMW_RD));
    assign bus_if.misaligned   = ~rst & idle & req_any & req_mis;
    assign bus_if.ack          = ~rst & ((state_q == DONE) | (idle & req_any & req_mis));
    assign bus_if.ram_write_en = ~rst & ((accept & ~bus_if.req_read & (req_size_dec == SZ_WORD))
                                         | (state_q == RMW_RD));
    assign bus_if.ram_din      = (state_q == RMW_RD) ? merge_word : bus_if.req_wdata;
    assign bus_if.ram_addr     = rst  ? '0 :
                                 idle ? bus_if.req_addr[ADDR_WIDTH+1:2] : addr_q[ADDR_WIDTH+1:2];
    assign bus_if.rdata        = rdata_q;

endmodule

// File: tb/tb_ru_mem_ctrl.sv
// Bench for ru_mem_ctrl: directed requests with a RAM model and a scoreboard.
module tb_ru_mem_ctrl;
    import ru_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ru_mem_ctrl_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

    ru_mem_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    logic [31:0] mem [0:4095];
    logic        bd_we = 1'b0;
    logic [11:0] bd_addr = '0;
    logic [31:0] bd_data = '0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (bus.ram_write_en) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    typedef struct packed { logic mis; logic [31:0] rdata; } resp_t;
    typedef struct packed { logic [11:0] addr; logic [31:0] din; } wr_t;
    resp_t resp_q[$];
    wr_t   wr_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares every ack and every RAM write against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ack) begin
                if (resp_q.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
                else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    check("ack_misaligned", {31'd0, bus.misaligned}, {31'd0, r.mis});
                    check("ack_rdata", bus.rdata, r.rdata);
                end
            end
            if (bus.ram_write_en) begin
                if (wr_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
                else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("write_addr", {20'd0, bus.ram_addr}, {20'd0, w.addr});
                    check("write_din", bus.ram_din, w.din);
                end
            end
        end
    end

    task automatic backdoor(input logic [11:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Called just after a rising edge; that cycle is cycle 0 of the request.
    task automatic issue(input string nm, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] wd, input int exp_busy, input int exp_ack,
                         input int exp_wr, input logic exp_mis, input logic [31:0] exp_rd,
                         input logic [11:0] exp_waddr, input logic [31:0] exp_wdin);
        int ack_c;
        int wr_c;
        ack_c = -1;
        wr_c  = -1;
        resp_q.push_back('{mis: exp_mis, rdata: exp_rd});
        if (exp_wr >= 0) wr_q.push_back('{addr: exp_waddr, din: exp_wdin});
        bus.req_read = rd; bus.req_write = wr; bus.req_addr = addr;
        bus.req_size = sz; bus.req_unsigned = uns; bus.req_wdata = wd;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check({nm, "_busy"}, {31'd0, bus.busy}, (c < exp_busy) ? 32'd1 : 32'd0);
            if (bus.ram_write_en) wr_c = c;
            if (bus.ack) begin
                ack_c = c;
                break;
            end
        end
        @(posedge clk); #1;
        bus.req_read = 1'b0; bus.req_write = 1'b0;
        check({nm, "_ack_cycle"}, ack_c, exp_ack);
        check({nm, "_write_cycle"}, wr_c, exp_wr);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_read = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h10;
        bus.req_size = 2'b10; bus.req_unsigned = 1'b0; bus.req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_ack", {31'd0, bus.ack}, 32'd0);
        check("rst_misaligned", {31'd0, bus.misaligned}, 32'd0);
        check("rst_write_en", {31'd0, bus.ram_write_en}, 32'd0);
        check("rst_ram_addr", {20'd0, bus.ram_addr}, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        bus.req_read = 1'b0;
        rst = 1'b0;
        backdoor(12'd4, 32'h8899AABB);
        backdoor(12'd5, 32'h00000000);

        @(posedge clk); #1;
        issue("lw10",  1, 0, 32'h10, 2'b10, 0, 32'h0, 2, 2, -1, 0, 32'h8899AABB, 12'd0, 32'h0);
        issue("lb13",  1, 0, 32'h13, 2'b00, 0, 32'h0, 2, 2, -1, 0, 32'hFFFFFF88, 12'd0, 32'h0);
        issue("lbu11", 1, 0, 32'h11, 2'b00, 1, 32'h0, 2, 2, -1, 0, 32'h000000AA, 12'd0, 32'h0);
        issue("lh12",  1, 0, 32'h12, 2'b01, 0, 32'h0, 2, 2, -1, 0, 32'hFFFF8899, 12'd0, 32'h0);
        issue("lhu10", 1, 0, 32'h10, 2'b01, 1, 32'h0, 2, 2, -1, 0, 32'h0000AABB, 12'd0, 32'h0);
        issue("sb11",  0, 1, 32'h11, 2'b00, 0, 32'h12345677, 2, 2, 1, 0, 32'h0000AABB, 12'd4, 32'h889977BB);
        issue("lw10b", 1, 0, 32'h10, 2'b10, 0, 32'h0, 2, 2, -1, 0, 32'h889977BB, 12'd0, 32'h0);
        issue("sw14",  0, 1, 32'h14, 2'b10, 0, 32'hDEADBEEF, 1, 1, 0, 0, 32'h889977BB, 12'd5, 32'hDEADBEEF);
        issue("lw14",  1, 0, 32'h14, 2'b10, 0, 32'h0, 2, 2, -1, 0, 32'hDEADBEEF, 12'd0, 32'h0);
        issue("lh11",  1, 0, 32'h11, 2'b01, 0, 32'h0, 0, 0, -1, 1, 32'hDEADBEEF, 12'd0, 32'h0);
        issue("sw12",  0, 1, 32'h12, 2'b10, 0, 32'h11223344, 0, 0, -1, 1, 32'hDEADBEEF, 12'd0, 32'h0);
        // Read and write together with size 11: word read wins, nothing written.
        issue("rdwr10", 1, 1, 32'h10, 2'b11, 0, 32'hCAFEF00D, 2, 2, -1, 0, 32'h889977BB, 12'd0, 32'h0);
        issue("sh16",  0, 1, 32'h16, 2'b01, 0, 32'hFFFF1234, 2, 2, 1, 0, 32'h889977BB, 12'd5, 32'h1234BEEF);
        check("mem4_after_misaligned", mem[4], 32'h889977BB);
        check("mem5_after_sh", mem[5], 32'h1234BEEF);

        // Abort a sub-word store by resetting while it waits on the RAM read.
        backdoor(12'd4, 32'h8899AABB);
        bus.req_write = 1'b1; bus.req_read = 1'b0; bus.req_addr = 32'h10;
        bus.req_size = 2'b01; bus.req_wdata = 32'h00005555;
        @(negedge clk);
        check("shrst_busy_c0", {31'd0, bus.busy}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("shrst_write_en", {31'd0, bus.ram_write_en}, 32'd0);
        check("shrst_busy", {31'd0, bus.busy}, 32'd0);
        check("shrst_ram_addr", {20'd0, bus.ram_addr}, 32'd0);
        check("shrst_rdata", bus.rdata, 32'd0);
        bus.req_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("shrst_idle_busy", {31'd0, bus.busy}, 32'd0);
        check("shrst_idle_ack", {31'd0, bus.ack}, 32'd0);
        repeat (2) @(negedge clk);
        check("shrst_mem4", mem[4], 32'h8899AABB);
        @(posedge clk); #1;
        issue("lw10c", 1, 0, 32'h10, 2'b10, 0, 32'h0, 2, 2, -1, 0, 32'h8899AABB, 12'd0, 32'h0);

        repeat (3) @(posedge clk);
        check("resp_queue_empty", resp_q.size(), 32'd0);
        check("write_queue_empty", wr_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
